// File: rtl/add_arbiter.sv
// Round-robin arbiter granting N requesters access to one shared W-bit adder.
// Each transaction runs IDLE -> CALC -> OUT, with the result held until sum_ready.
module add_arbiter #(
   parameter int N = 4,
   parameter int W = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic [N*W-1:0]       a_in,
   input  logic [N*W-1:0]       b_in,
   output logic [N-1:0]         gnt,
   output logic [W:0]           sum_out,
   output logic [$clog2(N)-1:0] sum_id,
   output logic                 sum_valid,
   input  logic                 sum_ready,
   output logic                 busy,
   output logic [7:0]           done_cnt
);

   localparam int IW = $clog2(N);
   localparam logic [N-1:0] ONE = N'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [N-1:0]   gnt_q, gnt_d;
   logic [W:0]     sum_q, sum_d;
   logic [IW-1:0]  id_q, id_d;
   logic           valid_q, valid_d;
   logic [7:0]     done_q, done_d;
   logic [IW-1:0]  rr_q, rr_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;

   logic           found;
   logic [IW-1:0]  win;
   logic [IW:0]    idx;
   logic [IW:0]    nxt;

   // Search upward from rr_q, wrapping modulo N; first set bit wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = {1'b0, rr_q} + (IW+1)'(k);
         if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
         if (!found && req[idx[IW-1:0]]) begin
            found = 1'b1;
            win   = idx[IW-1:0];
         end
      end
      nxt = {1'b0, win} + (IW+1)'(1);
      if (nxt == (IW+1)'(N)) nxt = '0;
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sum_d   = sum_q;
      id_d    = id_q;
      valid_d = valid_q;
      done_d  = done_q;
      rr_d    = rr_q;
      a_d     = a_q;
      b_d     = b_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               a_d     = a_in[int'(win)*W +: W];
               b_d     = b_in[int'(win)*W +: W];
               gnt_d   = ONE << win;
               id_d    = win;
               rr_d    = nxt[IW-1:0];
               state_d = CALC;
            end
         end
         CALC: begin
            sum_d   = {1'b0, a_q} + {1'b0, b_q};
            valid_d = 1'b1;
            gnt_d   = '0;
            state_d = OUT;
         end
         OUT: begin
            if (sum_ready) begin
               valid_d = 1'b0;
               done_d  = done_q + 8'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         sum_q   <= '0;
         id_q    <= '0;
         valid_q <= 1'b0;
         done_q  <= '0;
         rr_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sum_q   <= sum_d;
         id_q    <= id_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         rr_q    <= rr_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   assign gnt       = gnt_q;
   assign sum_out   = sum_q;
   assign sum_id    = id_q;
   assign sum_valid = valid_q;
   assign done_cnt  = done_q;
   assign busy      = (state_q != IDLE);

endmodule
